cpu_mul_sequencer: RTL and testbench

Multi-cycle controller that drives the CPU's three-product 16x16 multiplier cell to produce full 32x32 multiply results. It accepts one request at a time over a valid/ready handshake and runs the cell once for the low word or twice for the high word, feeding hi*hi operands on the second pass. It combines the partial products, applies signed correction, and returns a 32-bit result over a valid/ready response channel. It sits between the execute-stage issue logic and the multiplier cell, and is the only master of that cell.

---
 rtl/cpu_mul_pkg.sv | 25 ++
 rtl/cpu_mul_combine.sv | 37 +++
 rtl/cpu_mul_sequencer.sv | 125 ++++++++++++
 tb/tb_cpu_mul_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mul_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_mul_pkg : shared op encodings, states and widths for the mul sequencer
// Revision    : 1.0
// ---------------------------------------------------------------------------
package cpu_mul_pkg;

    localparam int MUL_HALF_W = 16;
    localparam int MUL_W      = 32;

    localparam logic [1:0] MUL_OP_MUL    = 2'd0;
    localparam logic [1:0] MUL_OP_MULXUU = 2'd1;
    localparam logic [1:0] MUL_OP_MULXSU = 2'd2;
    localparam logic [1:0] MUL_OP_MULXSS = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_CAP1  = 3'd2,
        ST_CAP2  = 3'd3,
        ST_RSP   = 3'd4
    } mul_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_mul_combine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_mul_combine : merges cell partial products into low / corrected high word
// Revision        : 1.0
// ---------------------------------------------------------------------------
module cpu_mul_combine
    import cpu_mul_pkg::*;
(
    input  logic [MUL_W-1:0] i_ll,
    input  logic [MUL_W:0]   i_mid,
    input  logic [MUL_W-1:0] i_hh,
    input  logic [MUL_W-1:0] i_a,
    input  logic [MUL_W-1:0] i_b,
    input  logic [1:0]       i_op,
    output logic [MUL_W-1:0] o_lo,
    output logic [MUL_W-1:0] o_hi
);

    logic [MUL_W:0]   w_low_sum;
    logic [MUL_W-1:0] w_hi_unsigned;
    logic [MUL_W-1:0] w_corr_a;
    logic [MUL_W-1:0] w_corr_b;

    // Only mid[15:0] lands in the low word; its carry plus mid[32:16] go high.
    assign w_low_sum     = {1'b0, i_ll} + {1'b0, i_mid[MUL_HALF_W-1:0], {MUL_HALF_W{1'b0}}};
    assign w_hi_unsigned = i_hh + {{(MUL_W-1){1'b0}}, w_low_sum[MUL_W]}
                         + {{(MUL_HALF_W-1){1'b0}}, i_mid[MUL_W:MUL_HALF_W]};

    assign w_corr_a = ((i_op == MUL_OP_MULXSU || i_op == MUL_OP_MULXSS) && i_a[MUL_W-1])
                    ? i_b : '0;
    assign w_corr_b = (i_op == MUL_OP_MULXSS && i_b[MUL_W-1]) ? i_a : '0;

    assign o_lo = w_low_sum[MUL_W-1:0];
    assign o_hi = w_hi_unsigned - w_corr_a - w_corr_b;

endmodule
`default_nettype wire

// File: rtl/cpu_mul_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_mul_sequencer : drives the 16x16 three-product cell for 32x32 multiplies
// Revision          : 1.0
// ---------------------------------------------------------------------------
module cpu_mul_sequencer
    import cpu_mul_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [MUL_W-1:0] req_a,
    input  logic [MUL_W-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [MUL_W-1:0] rsp_data,
    output logic [MUL_W-1:0] cell_src1,
    output logic [MUL_W-1:0] cell_src2,
    output logic             cell_en,
    input  logic [MUL_W-1:0] cell_p1,
    input  logic [MUL_W-1:0] cell_p2,
    input  logic [MUL_W-1:0] cell_p3
);

    mul_seq_state_t   r_state;
    mul_seq_state_t   w_state_nxt;
    logic [MUL_W-1:0] r_a;
    logic [MUL_W-1:0] r_b;
    logic [1:0]       r_op;
    logic [MUL_W-1:0] r_ll;
    logic [MUL_W:0]   r_mid;
    logic [MUL_W-1:0] r_result;

    logic [MUL_W:0]   w_mid_live;
    logic [MUL_W-1:0] w_ll_sel;
    logic [MUL_W:0]   w_mid_sel;
    logic [MUL_W-1:0] w_lo;
    logic [MUL_W-1:0] w_hi;
    logic             w_is_mul;

    assign w_is_mul   = (r_op == MUL_OP_MUL);
    assign w_mid_live = {1'b0, cell_p2} + {1'b0, cell_p3};
    // Pass-1 products are combined live in CAP1; CAP2 uses the captured copies.
    assign w_ll_sel   = (r_state == ST_CAP1) ? cell_p1    : r_ll;
    assign w_mid_sel  = (r_state == ST_CAP1) ? w_mid_live : r_mid;

    cpu_mul_combine u_combine (
        .i_ll  (w_ll_sel),
        .i_mid (w_mid_sel),
        .i_hh  (cell_p1),
        .i_a   (r_a),
        .i_b   (r_b),
        .i_op  (r_op),
        .o_lo  (w_lo),
        .o_hi  (w_hi)
    );

    always_comb begin
        w_state_nxt = r_state;
        cell_en     = 1'b0;
        cell_src1   = '0;
        cell_src2   = '0;
        case (r_state)
            ST_IDLE:  if (req_valid) w_state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                cell_en     = 1'b1;
                cell_src1   = r_a;
                cell_src2   = r_b;
                w_state_nxt = ST_CAP1;
            end
            ST_CAP1: begin
                if (w_is_mul) begin
                    w_state_nxt = ST_RSP;
                end else begin
                    cell_en     = 1'b1;
                    cell_src1   = {{MUL_HALF_W{1'b0}}, r_a[MUL_W-1:MUL_HALF_W]};
                    cell_src2   = {{MUL_HALF_W{1'b0}}, r_b[MUL_W-1:MUL_HALF_W]};
                    w_state_nxt = ST_CAP2;
                end
            end
            ST_CAP2:  w_state_nxt = ST_RSP;
            ST_RSP:   if (rsp_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= MUL_OP_MUL;
            r_ll     <= '0;
            r_mid    <= '0;
            r_result <= '0;
        end else begin
            if (r_state == ST_IDLE && req_valid) begin
                r_a  <= req_a;
                r_b  <= req_b;
                r_op <= req_op;
            end
            if (r_state == ST_CAP1) begin
                r_ll  <= cell_p1;
                r_mid <= w_mid_live;
                if (w_is_mul) r_result <= w_lo;
            end
            if (r_state == ST_CAP2) r_result <= w_hi;
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RSP);
    assign rsp_data  = r_result;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mul_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cpu_mul_sequencer : vector table + random requests against a 64-bit model
// Revision             : 1.0
// ---------------------------------------------------------------------------
module tb_cpu_mul_sequencer;
    import cpu_mul_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] cell_src1, cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1, cell_p2, cell_p3;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cpu_mul_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .cell_src1 (cell_src1),
        .cell_src2 (cell_src2),
        .cell_en   (cell_en),
        .cell_p1   (cell_p1),
        .cell_p2   (cell_p2),
        .cell_p3   (cell_p3)
    );

    // Multiplier cell: registered products, cleared by the same reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cell_p1 <= '0;
            cell_p2 <= '0;
            cell_p3 <= '0;
        end else if (cell_en) begin
            cell_p1 <= 32'(cell_src1[15:0])  * 32'(cell_src2[15:0]);
            cell_p2 <= 32'(cell_src1[15:0])  * 32'(cell_src2[31:16]);
            cell_p3 <= 32'(cell_src1[31:16]) * 32'(cell_src2[15:0]);
        end
    end

    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a, b);
        logic signed [63:0] sa, sb;
        logic [63:0] p;
        sa = $signed({32'h0, a});
        sb = $signed({32'h0, b});
        if (op == MUL_OP_MULXSU || op == MUL_OP_MULXSS) sa = $signed({{32{a[31]}}, a});
        if (op == MUL_OP_MULXSS)                        sb = $signed({{32{b[31]}}, b});
        p = 64'(sa * sb);
        return (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic run_req(input logic [1:0] op, input logic [31:0] a, b, exp,
                           input int hold, input string tag);
        int en_cnt;
        int lat;
        en_cnt = 0;
        lat    = 0;
        @(negedge clk);
        chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
        rsp_ready = (hold == 0);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            if (c > 1) @(negedge clk);
            if (cell_en) en_cnt++;
            if (c == 1) begin
                chk({tag, " src1 pass1"}, cell_src1, a);
                chk({tag, " src2 pass1"}, cell_src2, b);
            end
            if (c == 2 && op != MUL_OP_MUL) begin
                chk({tag, " src1 pass2"}, cell_src1, {16'h0, a[31:16]});
                chk({tag, " src2 pass2"}, cell_src2, {16'h0, b[31:16]});
            end
            if (rsp_valid) lat = c;
            else chk({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
        end
        if (lat == 0) begin
            chk({tag, " rsp timeout"}, 32'd0, 32'd1);
            rsp_ready = 1'b1;
            return;
        end
        chk({tag, " latency"}, 32'(lat), (op == MUL_OP_MUL) ? 32'd3 : 32'd4);
        chk({tag, " cell_en pulses"}, 32'(en_cnt), (op == MUL_OP_MUL) ? 32'd1 : 32'd2);
        chk({tag, " rsp_data"}, rsp_data, exp);
        for (int h = 0; h < hold; h++) begin
            chk({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " hold data"}, rsp_data, exp);
            chk({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
            chk({tag, " hold cell_en"}, 32'(cell_en), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, " idle rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " idle req_ready"}, 32'(req_ready), 32'd1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          hold;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        tbl[0] = '{MUL_OP_MUL,    32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 0};
        tbl[1] = '{MUL_OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0};
        tbl[2] = '{MUL_OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0};
        tbl[3] = '{MUL_OP_MULXSS, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 0};
        tbl[4] = '{MUL_OP_MULXSU, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 0};
        tbl[5] = '{MUL_OP_MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0};
        tbl[6] = '{MUL_OP_MUL,    32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 5};
        tbl[7] = '{MUL_OP_MULXSS, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0};
        tbl[8] = '{MUL_OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0};

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = MUL_OP_MUL;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #1;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_data",  rsp_data, 32'd0);
        chk("reset cell_en",   32'(cell_en), 32'd0);
        chk("reset cell_src1", cell_src1, 32'd0);
        chk("reset cell_src2", cell_src2, 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_req(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].hold,
                    $sformatf("vec%0d", i));

        // Reset during CAP1 of a MULX aborts it with no response.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = MUL_OP_MULXSS;
        req_a     = 32'h1234_5678;
        req_b     = 32'h9ABC_DEF0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort cap1 cell_en", 32'(cell_en), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort rsp_data",  rsp_data, 32'd0);
        chk("abort cell_en",   32'(cell_en), 32'd0);
        chk("abort cell_src1", cell_src1, 32'd0);
        chk("abort cell_src2", cell_src2, 32'd0);
        chk("abort req_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort no rsp", 32'(rsp_valid), 32'd0);
        end
        reset_n = 1'b1;
        run_req(MUL_OP_MUL, 32'd3, 32'd5, 32'h0000_000F, 0, "post-abort");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post-abort quiet", 32'(rsp_valid), 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 8 == 0) ra = {ra[31], 31'h0};
            if (i % 8 == 1) rb = 32'hFFFF_FFFF;
            run_req(rop, ra, rb, ref_model(rop, ra, rb), int'($urandom_range(0, 2)),
                    $sformatf("rnd%0d op%0d", i, rop));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
